// File: rtl/sram_mem_controller.sv
// Data-memory stage sequencer for a 16-bit asynchronous SRAM: every 32-bit
// load/store becomes a low then a high half-word phase of WAIT_CYCLES cycles each.
module sram_mem_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  localparam int unsigned CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned WORD_W = SRAM_AW - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_c, start_c, low_done_c, high_done_c;
  logic [WORD_W-1:0] word_c;
  logic              lat_wr;
  logic [WORD_W-1:0] lat_word;
  logic [15:0]       lat_wdata_hi;

  assign req_c  = rd_en | wr_en;
  // Word index relative to the SRAM base; upper bits drop so accesses wrap.
  assign word_c = WORD_W'((address - 32'(BASE_ADDR)) >> 2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ready stays combinational in IDLE so a request freezes the pipeline the same cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready       = 1'b0;
    start_c     = 1'b0;
    low_done_c  = 1'b0;
    high_done_c = 1'b0;
    case (state_q)
      IDLE: begin
        ready = ~req_c;
        if (req_c) begin
          start_c = 1'b1;
          cnt_d   = '0;
          state_d = LOW;
        end
      end
      LOW: begin
        if (cnt_q == CNT_LAST) begin
          low_done_c = 1'b1;
          cnt_d      = '0;
          state_d    = HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (cnt_q == CNT_LAST) begin
          high_done_c = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM pins are loaded one edge ahead so they line up with the phase states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data    <= '0;
      sram_addr    <= '0;
      sram_dq_out  <= '0;
      sram_dq_oe   <= 1'b0;
      sram_we_n    <= 1'b1;
      lat_wr       <= 1'b0;
      lat_word     <= '0;
      lat_wdata_hi <= '0;
    end else begin
      if (start_c) begin
        lat_wr       <= wr_en;
        lat_word     <= word_c;
        lat_wdata_hi <= write_data[31:16];
        sram_addr    <= {word_c, 1'b0};
        sram_dq_out  <= write_data[15:0];
        sram_dq_oe   <= wr_en;
        sram_we_n    <= ~wr_en;
      end
      if (low_done_c) begin
        if (!lat_wr) read_data[15:0] <= sram_dq_in;
        sram_addr   <= {lat_word, 1'b1};
        sram_dq_out <= lat_wdata_hi;
      end
      if (high_done_c) begin
        if (!lat_wr) read_data[31:16] <= sram_dq_in;
        sram_dq_oe <= 1'b0;
        sram_we_n  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: directed vector table, reset corner cases and
// random accesses checked against a word-level memory model.
module tb_sram_mem_controller;

  localparam int W = 2;

  logic        clk, rst, rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready, sram_dq_oe, sram_we_n;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;

  sram_mem_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(W), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical SRAM seen through the pins.
  logic [15:0] mem [0:262143];
  assign sram_dq_in = mem[sram_addr];
  always @(posedge clk) if (!sram_we_n) mem[sram_addr] = sram_dq_out;

  // Reference: 32-bit words indexed by word number, plus last load result.
  logic [31:0] ref_mem [logic [16:0]];
  logic [31:0] model_rd;
  logic [17:0] last_addr;
  int errors = 0;
  int checks = 0;

  function automatic logic [15:0] pat(input logic [17:0] a);
    return 16'((32'(a) * 32'h9E3779B1) >> 13);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [16:0] idx);
    if (ref_mem.exists(idx)) return ref_mem[idx];
    return {pat({idx, 1'b1}), pat({idx, 1'b0})};
  endfunction

  task automatic preload(input logic [16:0] idx, input logic [31:0] w);
    ref_mem[idx] = w;
    mem[{idx, 1'b0}] = w[15:0];
    mem[{idx, 1'b1}] = w[31:16];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
      @(negedge clk);
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_we_n", 32'(sram_we_n), 32'd1);
      chk("idle_oe", 32'(sram_dq_oe), 32'd0);
      chk("idle_addr_hold", 32'(sram_addr), 32'(last_addr));
    end
  endtask

  // One access from the IDLE cycle to DONE; req is held for `hold` cycles.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int hold,
                            output logic [31:0] rd_obs, output logic [17:0] lo_obs);
    logic [16:0] idx;
    logic        half;
    idx    = 17'((addr - 32'd1024) >> 2);
    lo_obs = '0;
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; address = addr; write_data = wdata;
    @(negedge clk);
    chk("req_ready", 32'(ready), 32'd0);
    for (int k = 1; k <= 2 * W + 1; k++) begin
      @(posedge clk); #1;
      address = $urandom; write_data = $urandom;
      if (k >= hold) begin rd_en = 1'b0; wr_en = 1'b0; end
      @(negedge clk);
      if (k <= 2 * W) begin
        half = (k > W) ? 1'b1 : 1'b0;
        if (k == 1) lo_obs = sram_addr;
        chk("busy_ready", 32'(ready), 32'd0);
        chk("phase_addr", 32'(sram_addr), 32'({idx, half}));
        chk("phase_we_n", 32'(sram_we_n), 32'(!wr));
        chk("phase_oe", 32'(sram_dq_oe), 32'(wr));
        if (wr) chk("phase_dq_out", 32'(sram_dq_out), half ? 32'(wdata[31:16]) : 32'(wdata[15:0]));
      end
    end
    if (wr) ref_mem[idx] = wdata;
    else model_rd = ref_rd(idx);
    last_addr = {idx, 1'b1};
    chk("done_ready", 32'(ready), 32'd1);
    chk("done_we_n", 32'(sram_we_n), 32'd1);
    chk("done_oe", 32'(sram_dq_oe), 32'd0);
    chk("done_addr", 32'(sram_addr), 32'(last_addr));
    chk("read_data", read_data, model_rd);
    rd_obs = read_data;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic [17:0] exp_lo;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] rd_obs;
  logic [17:0] lo_obs;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 6, 32'h0,        18'h0};
    vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h0,        6, 32'h12345678, 18'h2};
    vecs[2] = '{1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 6, 32'h12345678, 18'h4};
    vecs[3] = '{1'b1, 1'b0, 32'd1032, 32'h0,        6, 32'hCAFEF00D, 18'h4};
    vecs[4] = '{1'b1, 1'b1, 32'd1036, 32'h11112222, 1, 32'hCAFEF00D, 18'h6};
    vecs[5] = '{1'b1, 1'b0, 32'd1020, 32'h0,        2, 32'hBBBBAAAA, 18'h3FFFE};
    vecs[6] = '{1'b1, 1'b0, 32'd1036, 32'h0,        3, 32'h11112222, 18'h6};
    vecs[7] = '{1'b1, 1'b0, 32'd1027, 32'h0,        1, 32'hDEADBEEF, 18'h0};

    for (int i = 0; i < 262144; i++) mem[i] = pat(18'(i));
    preload(17'h1, 32'h12345678);
    preload(17'h1FFFF, 32'hBBBBAAAA);

    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    model_rd = '0; last_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'h0);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    rst = 1'b1;
    idle_cycles(3);

    // Directed table, issued back to back.
    for (int i = 0; i < 8; i++) begin
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].hold,
                 rd_obs, lo_obs);
      chk("vec_rdata", rd_obs, vecs[i].exp_rdata);
      chk("vec_lo_addr", 32'(lo_obs), 32'(vecs[i].exp_lo));
    end
    idle_cycles(2);

    // Reset during the high phase of a write.
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1040; write_data = 32'h55AA33CC;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_we_n", 32'(sram_we_n), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_we_n", 32'(sram_we_n), 32'd1);
    chk("mid_rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("mid_rst_read_data", read_data, 32'h0);
    wr_en = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    model_rd = '0; last_addr = '0;
    // The aborted write left the SRAM undefined there; realign it with the model.
    preload(17'h4, ref_rd(17'h4));
    idle_cycles(2);
    run_access(1'b1, 1'b0, 32'd1040, 32'h0, 1, rd_obs, lo_obs);
    chk("post_rst_lo", 32'(lo_obs), 32'h8);

    // Random mix of loads, stores and both, with wrapping addresses and gaps.
    for (int i = 0; i < 40; i++) begin
      int          op, gap;
      logic [31:0] a;
      op = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) a = $urandom;
      else a = 32'd1024 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
      run_access(op != 1, op == 1 || op == 2, a, $urandom, $urandom_range(1, 7),
                 rd_obs, lo_obs);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle_cycles(gap);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
